hit_event_builder: RTL and testbench



---
 rtl/hit_event_builder.sv | 193 +++++++++++++++++++
 tb/tb_hit_event_builder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_event_builder.sv
// -----------------------------------------------------------------------------
// hit_event_builder
//
// Multi-channel hit collector for the pixel readout digital core. A
// round-robin arbiter picks one requesting channel per cycle. The granted hit
// is time-stamped and packed with the chip ID and an odd-parity bit. The
// packet then goes into a first-word-fall-through FIFO that feeds the UART
// transmit path. When the FIFO is full, the core either back-pressures the
// channels or drops the hit and counts it, selected by drop_on_full.
//
// Packet layout (LSB first):
//   [1:0] 2'b01 | chip_id | channel | timestamp | adc | trig | zero pad |
//   [WIDTH-1] odd parity (XOR of all WIDTH bits is 1)
//
// Ports
//   clk, reset        master clock, synchronous active-high reset
//   chip_id           chip ID stamped into every packet
//   timestamp         free-running timestamp, sampled in the grant cycle
//   channel_enable    per-channel enable mask
//   hit_req           per-channel request, held until acked
//   hit_trig_type     2-bit trigger type per channel
//   hit_adc           ADCBITS-wide ADC word per channel
//   drop_on_full      1: drop and count when full, 0: backpressure when full
//   clear_overflow    zeroes overflow_count
//   hit_ack           combinational one-hot grant for the current cycle
//   pkt_data          head-of-FIFO packet (0 while empty)
//   pkt_valid         FIFO not empty
//   pkt_ready         consumer accepts the head packet
//   fifo_count        registered occupancy
//   fifo_half         fifo_count >= FIFO_DEPTH/2
//   fifo_full         fifo_count == FIFO_DEPTH
//   overflow_count    dropped hits, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module hit_event_builder #(
  parameter int NUMCHANNELS = 64,
  parameter int ADCBITS     = 8,
  parameter int CHIP_ID_W   = 8,
  parameter int TS_W        = 28,
  parameter int WIDTH       = 64,
  parameter int FIFO_DEPTH  = 2048
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHIP_ID_W-1:0]           chip_id,
  input  logic [TS_W-1:0]                timestamp,
  input  logic [NUMCHANNELS-1:0]         channel_enable,
  input  logic [NUMCHANNELS-1:0]         hit_req,
  input  logic [2*NUMCHANNELS-1:0]       hit_trig_type,
  input  logic [NUMCHANNELS*ADCBITS-1:0] hit_adc,
  input  logic                           drop_on_full,
  input  logic                           clear_overflow,
  output logic [NUMCHANNELS-1:0]         hit_ack,
  output logic [WIDTH-1:0]               pkt_data,
  output logic                           pkt_valid,
  input  logic                           pkt_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           fifo_half,
  output logic                           fifo_full,
  output logic [15:0]                    overflow_count
);

  localparam int CW       = $clog2(NUMCHANNELS);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = AW + 1;
  localparam int OFF_CHIP = 2;
  localparam int OFF_CH   = OFF_CHIP + CHIP_ID_W;
  localparam int OFF_TS   = OFF_CH + CW;
  localparam int OFF_ADC  = OFF_TS + TS_W;
  localparam int OFF_TRIG = OFF_ADC + ADCBITS;

  // Parity bit value that makes the XOR over the whole packet equal 1.
  function automatic logic odd_parity(input logic [WIDTH-2:0] v);
    return ~^v;
  endfunction

  // Saturating increment for the overflow counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [CW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   half_q, full_q;
  logic [15:0]            ovf_q, ovf_d;
  logic [WIDTH-1:0]       mem [FIFO_DEPTH];

  logic [NUMCHANNELS-1:0] elig;
  logic                   gnt_found;
  logic [CW-1:0]          gnt_idx;
  logic [CW-1:0]          cand;
  logic                   grant, push, drop, pop;
  logic [ADCBITS-1:0]     adc_sel;
  logic [1:0]             trig_sel;
  logic [WIDTH-1:0]       pkt_w;

  assign elig = hit_req & channel_enable;

  // Round-robin search: first eligible channel strictly after rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUMCHANNELS; k++) begin
      cand = CW'((int'(rr_ptr_q) + k) % NUMCHANNELS);
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A grant is refused only when full and backpressure is selected. While
  // reset is high nothing is granted, so in-flight requests are discarded.
  assign grant = gnt_found && (!full_q || drop_on_full) && !reset;
  assign push  = grant && !full_q;
  assign drop  = grant && full_q;
  assign pop   = pkt_valid && pkt_ready;

  always_comb begin
    hit_ack  = '0;
    adc_sel  = '0;
    trig_sel = '0;
    for (int i = 0; i < NUMCHANNELS; i++) begin
      if (gnt_idx == CW'(i)) begin
        hit_ack[i] = grant;
        adc_sel    = hit_adc[i*ADCBITS +: ADCBITS];
        trig_sel   = hit_trig_type[2*i +: 2];
      end
    end
  end

  always_comb begin
    pkt_w                      = '0;
    pkt_w[1:0]                 = 2'b01;
    pkt_w[OFF_CHIP +: CHIP_ID_W] = chip_id;
    pkt_w[OFF_CH +: CW]        = gnt_idx;
    pkt_w[OFF_TS +: TS_W]      = timestamp;
    pkt_w[OFF_ADC +: ADCBITS]  = adc_sel;
    pkt_w[OFF_TRIG +: 2]       = trig_sel;
    pkt_w[WIDTH-1]             = odd_parity(pkt_w[WIDTH-2:0]);
  end

  always_comb begin
    rr_ptr_d = grant ? gnt_idx : rr_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A clear takes priority, but an overflow in the same cycle still counts.
    if (clear_overflow) ovf_d = {15'd0, drop};
    else if (drop)      ovf_d = sat_inc16(ovf_q);
    else                ovf_d = ovf_q;
  end

  // Control state boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= CW'(NUMCHANNELS - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      half_q   <= (count_d >= CNT_W'(FIFO_DEPTH / 2));
      full_q   <= (count_d == CNT_W'(FIFO_DEPTH));
      ovf_q    <= ovf_d;
    end
  end

  // Packet storage boundary.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= pkt_w;
  end

  assign pkt_valid      = (count_q != '0);
  assign pkt_data       = pkt_valid ? mem[rd_ptr_q] : '0;
  assign fifo_count     = count_q;
  assign fifo_half      = half_q;
  assign fifo_full      = full_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_hit_event_builder.sv
module tb_hit_event_builder;

  localparam int NCH = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      chip_id;
  logic [27:0]     timestamp;
  logic [NCH-1:0]  channel_enable;
  logic [NCH-1:0]  hit_req;
  logic [2*NCH-1:0] hit_trig_type;
  logic [NCH*8-1:0] hit_adc;
  logic            drop_on_full;
  logic            clear_overflow;
  logic [NCH-1:0]  hit_ack;
  logic [63:0]     pkt_data;
  logic            pkt_valid;
  logic            pkt_ready;
  logic [2:0]      fifo_count;
  logic            fifo_half;
  logic            fifo_full;
  logic [15:0]     overflow_count;

  hit_event_builder #(
    .NUMCHANNELS(NCH), .ADCBITS(8), .CHIP_ID_W(8), .TS_W(28),
    .WIDTH(64), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .chip_id(chip_id), .timestamp(timestamp),
    .channel_enable(channel_enable), .hit_req(hit_req),
    .hit_trig_type(hit_trig_type), .hit_adc(hit_adc),
    .drop_on_full(drop_on_full), .clear_overflow(clear_overflow),
    .hit_ack(hit_ack), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .fifo_count(fifo_count), .fifo_half(fifo_half),
    .fifo_full(fifo_full), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];
  logic [63:0] want;
  logic [63:0] ack_prev;
  bit          one_shot;
  logic [63:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference packet built from the stimulus currently applied.
  function automatic logic [63:0] model_pkt(input int ch);
    logic [62:0] lo;
    lo = {9'd0, hit_trig_type[2*ch +: 2], hit_adc[8*ch +: 8], timestamp,
          6'(ch), chip_id, 2'b01};
    return {~^lo, lo};
  endfunction

  // One clock cycle: called at posedge+1, leaves at the next posedge+1.
  task automatic cyc(input logic [63:0] exp_ack, input bit exp_push, input string tag);
    hit_req = want & ~ack_prev;
    #1;
    check(tag, hit_ack, exp_ack);
    if (exp_push && exp_ack != '0) sb.push_back(model_pkt(oh_idx(exp_ack)));
    ack_prev = hit_ack;
    if (one_shot) want = want & ~hit_ack;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    want     = '0;
    ack_prev = '0;
    hit_req  = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  // Scoreboard side: every accepted head packet is compared in order.
  always @(negedge clk) begin
    if (!reset && pkt_valid && pkt_ready) begin
      if (sb.size() == 0) check("pop_unexpected", 64'(pkt_valid), 64'd0);
      else begin
        mon_exp = sb.pop_front();
        check("pkt_data", pkt_data, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_a[6];
    int rr_b[4];
    rr_a = '{0, 1, 63, 0, 1, 63};
    rr_b = '{0, 63, 0, 63};
    reset = 1'b1; hit_req = '0; want = '0; ack_prev = '0; one_shot = 1'b0;
    channel_enable = '1; chip_id = 8'h3C; timestamp = '0;
    drop_on_full = 1'b0; clear_overflow = 1'b0; pkt_ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      hit_adc[8*i +: 8]       = 8'(i * 29 + 3);
      hit_trig_type[2*i +: 2] = 2'(i);
    end
    hit_adc[5*8 +: 8]  = 8'hA7;
    hit_trig_type[11:10] = 2'b10;

    // Reset state, with a request present during reset.
    repeat (2) @(posedge clk);
    #1;
    hit_req = 64'h20;
    #1;
    check("ack_in_reset", hit_ack, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; hit_req = '0;
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_valid", 64'(pkt_valid), 64'd0);
    check("rst_half", 64'(fifo_half), 64'd0);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_ovf", 64'(overflow_count), 64'd0);
    check("rst_data", pkt_data, 64'd0);

    // Single hit on channel 5.
    timestamp = 28'h0000123; want = 64'h20; one_shot = 1'b1;
    cyc(64'h20, 1'b1, "single_ack");
    check("single_valid", 64'(pkt_valid), 64'd1);
    check("single_type", 64'(pkt_data[1:0]), 64'd1);
    check("single_chip", 64'(pkt_data[9:2]), 64'h3C);
    check("single_chan", 64'(pkt_data[15:10]), 64'd5);
    check("single_ts", 64'(pkt_data[43:16]), 64'h123);
    check("single_adc", 64'(pkt_data[51:44]), 64'hA7);
    check("single_trig", 64'(pkt_data[53:52]), 64'd2);
    check("single_parity", 64'(^pkt_data), 64'd1);
    pkt_ready = 1'b1;
    cyc(64'd0, 1'b0, "single_idle");

    // Round robin over channels 0, 1, 63, then with channel 1 disabled.
    reset_dut();
    one_shot = 1'b0; pkt_ready = 1'b1;
    want = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 63);
    for (int k = 0; k < 6; k++) begin
      timestamp = 28'($urandom);
      cyc(64'd1 << rr_a[k], 1'b1, "rr_grant");
    end
    channel_enable = ~64'h2;
    for (int k = 0; k < 4; k++) begin
      timestamp = 28'($urandom);
      cyc(64'd1 << rr_b[k], 1'b1, "rr_masked_grant");
    end
    want = '0; channel_enable = '1;
    repeat (2) cyc(64'd0, 1'b0, "rr_idle");
    check("rr_drained", 64'(fifo_count), 64'd0);

    // Backpressure mode with depth 4.
    reset_dut();
    pkt_ready = 1'b0; drop_on_full = 1'b0; one_shot = 1'b1;
    want = 64'h3F << 10;
    for (int k = 0; k < 4; k++) begin
      timestamp = 28'($urandom);
      cyc(64'd1 << (10 + k), 1'b1, "bp_grant");
    end
    check("bp_full", 64'(fifo_full), 64'd1);
    check("bp_count", 64'(fifo_count), 64'd4);
    repeat (2) cyc(64'd0, 1'b0, "bp_stall");
    pkt_ready = 1'b1;
    cyc(64'd0, 1'b0, "bp_pop_cycle");
    pkt_ready = 1'b0;
    timestamp = 28'($urandom);
    cyc(64'd1 << 14, 1'b1, "bp_resume");
    cyc(64'd0, 1'b0, "bp_full_again");
    check("bp_count2", 64'(fifo_count), 64'd4);
    check("bp_ovf", 64'(overflow_count), 64'd0);
    want = '0; pkt_ready = 1'b1;
    repeat (4) cyc(64'd0, 1'b0, "bp_drain");
    check("bp_empty", 64'(fifo_count), 64'd0);

    // Drop mode with depth 4.
    reset_dut();
    pkt_ready = 1'b0; drop_on_full = 1'b1; one_shot = 1'b1;
    want = 64'h3F << 20;
    for (int k = 0; k < 6; k++) begin
      timestamp = 28'($urandom);
      cyc(64'd1 << (20 + k), k < 4, "drop_grant");
    end
    check("drop_count", 64'(fifo_count), 64'd4);
    check("drop_ovf", 64'(overflow_count), 64'd2);
    want = 64'd1 << 26; clear_overflow = 1'b1;
    cyc(64'd1 << 26, 1'b0, "drop_clr_hit");
    clear_overflow = 1'b0;
    check("drop_ovf_clr", 64'(overflow_count), 64'd1);

    // Simultaneous push and pop at count 2, then at full.
    pkt_ready = 1'b1;
    repeat (2) cyc(64'd0, 1'b0, "pp_drain");
    check("pp_count_before", 64'(fifo_count), 64'd2);
    want = 64'd1 << 30; timestamp = 28'($urandom);
    cyc(64'd1 << 30, 1'b1, "pp_grant");
    check("pp_count_same", 64'(fifo_count), 64'd2);
    check("pp_half", 64'(fifo_half), 64'd1);
    pkt_ready = 1'b0;
    want = (64'd1 << 31) | (64'd1 << 32);
    timestamp = 28'($urandom);
    cyc(64'd1 << 31, 1'b1, "pp_fill_a");
    timestamp = 28'($urandom);
    cyc(64'd1 << 32, 1'b1, "pp_fill_b");
    check("pp_full", 64'(fifo_full), 64'd1);
    pkt_ready = 1'b1; want = 64'd1 << 33;
    cyc(64'd1 << 33, 1'b0, "full_pushpop");
    pkt_ready = 1'b0;
    check("full_pushpop_count", 64'(fifo_count), 64'd3);
    check("full_pushpop_ovf", 64'(overflow_count), 64'd2);

    // Reset in the middle of traffic.
    drop_on_full = 1'b0;
    reset = 1'b1; want = 64'd1 << 40; hit_req = want;
    #1;
    check("midrst_ack", hit_ack, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; sb.delete(); ack_prev = '0;
    check("midrst_count", 64'(fifo_count), 64'd0);
    check("midrst_valid", 64'(pkt_valid), 64'd0);
    want = (64'd1 << 7) | (64'd1 << 50); one_shot = 1'b1;
    timestamp = 28'($urandom);
    cyc(64'd1 << 7, 1'b1, "postrst_first");
    timestamp = 28'($urandom);
    cyc(64'd1 << 50, 1'b1, "postrst_second");
    want = '0; pkt_ready = 1'b1;
    repeat (3) cyc(64'd0, 1'b0, "final_drain");
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
